// File: rtl/ir_frame_tx_if.sv
// ---------------------------------------------------------------------------
// ir_frame_tx_if
//
// Request/response bundle between the command builder (master) and the IR
// frame transmitter (slave).
//
//   tx_valid  master->slave  frame request
//   tx_ready  slave->master  transmitter idle, request will be accepted
//   seg0      master->slave  segment-0 payload (W0 bits, sent MSB first)
//   seg1      master->slave  segment-1 payload (W1 bits, sent MSB first)
//   rep       master->slave  extra repeats (frame is sent rep+1 times)
//   mod_en    master->slave  1 = gate the envelope with the carrier
//   ir_out    slave->master  IR LED drive
//   ir_env    slave->master  unmodulated envelope (high during marks)
//   busy      slave->master  inverse of tx_ready
//   done      slave->master  one-cycle pulse after the last frame
// ---------------------------------------------------------------------------
interface ir_frame_tx_if #(
    parameter int W0 = 35,
    parameter int W1 = 32
);
    logic          tx_valid;
    logic          tx_ready;
    logic [W0-1:0] seg0;
    logic [W1-1:0] seg1;
    logic [3:0]    rep;
    logic          mod_en;
    logic          ir_out;
    logic          ir_env;
    logic          busy;
    logic          done;

    modport master (
        output tx_valid, seg0, seg1, rep, mod_en,
        input  tx_ready, ir_out, ir_env, busy, done
    );

    modport slave (
        input  tx_valid, seg0, seg1, rep, mod_en,
        output tx_ready, ir_out, ir_env, busy, done
    );
endinterface

// File: rtl/ir_frame_tx.sv
// ---------------------------------------------------------------------------
// ir_frame_tx
//
// Parametrised IR frame transmitter. A frame is: lead code, segment 0,
// connect code, segment 1, stop mark; it is optionally repeated with a
// FRAME_GAP space between copies. Data bits are pulse-distance coded: every
// bit is a BIT_MARK mark followed by ZERO_SPACE or ONE_SPACE.
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-low reset
//   bus  ir_frame_tx_if.slave (request handshake, payload, IR outputs)
//
// All outputs are registered: each is computed from the next state so it
// changes on the same edge as the state register.
// ---------------------------------------------------------------------------
module ir_frame_tx #(
    parameter int W0         = 35,
    parameter int W1         = 32,
    parameter int CAR_DIV    = 2632,
    parameter int LEAD_MARK  = 900000,
    parameter int LEAD_SPACE = 450000,
    parameter int BIT_MARK   = 56000,
    parameter int ZERO_SPACE = 56000,
    parameter int ONE_SPACE  = 168000,
    parameter int CONN_MARK  = 56000,
    parameter int CONN_SPACE = 2000000,
    parameter int FRAME_GAP  = 4000000,
    parameter int CNT_W      = 23
) (
    input  logic         clk,
    input  logic         rst,
    ir_frame_tx_if.slave bus
);

    localparam int WMAX = (W0 > W1) ? W0 : W1;
    localparam int BW   = (WMAX > 1) ? $clog2(WMAX) : 1;
    localparam int PW   = $clog2(CAR_DIV);

    typedef enum logic [3:0] {
        IDLE, LEAD_M, LEAD_S, S0_M, S0_S, CONN_M, CONN_S,
        S1_M, S1_S, STOP_M, GAP, DONE
    } state_t;

    state_t         state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dur_m1;
    logic [BW-1:0]  bit_idx;
    logic [3:0]     rep_cnt;
    logic [PW-1:0]  phase, phase_nxt;
    logic [W0-1:0]  seg0_q, seg0_sh;
    logic [W1-1:0]  seg1_q, seg1_sh;
    logic           mod_q, mod_nxt;
    logic           cur_bit;
    logic           timer_done;
    logic           accept;
    logic           carrier_nxt;
    logic           entering;

    logic ir_out_q, ir_env_q, tx_ready_q, busy_q, done_q;

    assign bus.ir_out   = ir_out_q;
    assign bus.ir_env   = ir_env_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    function automatic logic is_mark(input state_t s);
        return (s == LEAD_M) || (s == S0_M) || (s == CONN_M) ||
               (s == S1_M)   || (s == STOP_M);
    endfunction

    // Next-state and duration decode.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        seg0_sh    = seg0_q >> bit_idx;
        seg1_sh    = seg1_q >> bit_idx;
        cur_bit    = 1'b0;
        dur_m1     = '0;
        state_nxt  = state;
        accept     = (state == IDLE) && bus.tx_valid;

        if (state == S0_S)      cur_bit = seg0_sh[0];
        else if (state == S1_S) cur_bit = seg1_sh[0];

        case (state)
            LEAD_M:               dur_m1 = CNT_W'(LEAD_MARK - 1);
            LEAD_S:               dur_m1 = CNT_W'(LEAD_SPACE - 1);
            S0_M, S1_M, STOP_M:   dur_m1 = CNT_W'(BIT_MARK - 1);
            S0_S, S1_S:           dur_m1 = cur_bit ? CNT_W'(ONE_SPACE - 1)
                                                   : CNT_W'(ZERO_SPACE - 1);
            CONN_M:               dur_m1 = CNT_W'(CONN_MARK - 1);
            CONN_S:               dur_m1 = CNT_W'(CONN_SPACE - 1);
            GAP:                  dur_m1 = CNT_W'(FRAME_GAP - 1);
            default:              dur_m1 = '0;
        endcase
        timer_done = (cnt == dur_m1);

        case (state)
            IDLE:   if (accept)     state_nxt = LEAD_M;
            LEAD_M: if (timer_done) state_nxt = LEAD_S;
            LEAD_S: if (timer_done) state_nxt = S0_M;
            S0_M:   if (timer_done) state_nxt = S0_S;
            S0_S:   if (timer_done) state_nxt = (bit_idx == '0) ? CONN_M : S0_M;
            CONN_M: if (timer_done) state_nxt = CONN_S;
            CONN_S: if (timer_done) state_nxt = S1_M;
            S1_M:   if (timer_done) state_nxt = S1_S;
            S1_S:   if (timer_done) state_nxt = (bit_idx == '0) ? STOP_M : S1_M;
            STOP_M: if (timer_done) state_nxt = (rep_cnt != 4'd0) ? GAP : DONE;
            GAP:    if (timer_done) state_nxt = LEAD_M;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase

        entering = (state_nxt != state);

        // Carrier phase restarts on the first cycle of every mark so each
        // mark begins with a full carrier high half-period.
        if (state_nxt == IDLE || (entering && is_mark(state_nxt)))
            phase_nxt = '0;
        else if (phase == PW'(CAR_DIV - 1))
            phase_nxt = '0;
        else
            phase_nxt = phase + PW'(1);

        mod_nxt     = accept ? bus.mod_en : mod_q;
        carrier_nxt = (phase_nxt < PW'(CAR_DIV / 2));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rep_cnt    <= '0;
            phase      <= '0;
            // NOTE: the shadow payload is reset too, so no X can reach the
            // outputs even if a synthesis flow reorders the first accept.
            seg0_q     <= '0;
            seg1_q     <= '0;
            mod_q      <= 1'b0;
            ir_out_q   <= 1'b0;
            ir_env_q   <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;

            if (entering || state_nxt == IDLE) cnt <= '0;
            else                               cnt <= cnt + CNT_W'(1);

            if (accept) begin
                seg0_q  <= bus.seg0;
                seg1_q  <= bus.seg1;
                rep_cnt <= bus.rep;
                mod_q   <= bus.mod_en;
            end else if (state == STOP_M && state_nxt == GAP) begin
                rep_cnt <= rep_cnt - 4'd1;
            end

            // Bit index is reloaded on entry to each segment's first mark
            // and stepped down between bits; it never wraps.
            if (state == LEAD_S && state_nxt == S0_M)
                bit_idx <= BW'(W0 - 1);
            else if (state == CONN_S && state_nxt == S1_M)
                bit_idx <= BW'(W1 - 1);
            else if ((state == S0_S && state_nxt == S0_M) ||
                     (state == S1_S && state_nxt == S1_M))
                bit_idx <= bit_idx - BW'(1);

            ir_env_q   <= is_mark(state_nxt);
            ir_out_q   <= is_mark(state_nxt) & (~mod_nxt | carrier_nxt);
            tx_ready_q <= (state_nxt == IDLE);
            busy_q     <= (state_nxt != IDLE);
            done_q     <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_ir_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_ir_frame_tx
//
// Directed, table-driven bench for ir_frame_tx with small timing parameters.
// Each table row carries a request and hand-computed totals (frame length to
// done, envelope-high cycles, ir_out-high cycles); the cycle-by-cycle
// waveform is also compared with a reference built from the frame format.
// Hand-written sequences cover held requests with changing inputs and an
// asynchronous reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_ir_frame_tx;

    localparam int W0         = 3;
    localparam int W1         = 2;
    localparam int CAR_DIV    = 4;
    localparam int LEAD_MARK  = 8;
    localparam int LEAD_SPACE = 4;
    localparam int BIT_MARK   = 2;
    localparam int ZERO_SPACE = 2;
    localparam int ONE_SPACE  = 4;
    localparam int CONN_MARK  = 2;
    localparam int CONN_SPACE = 6;
    localparam int FRAME_GAP  = 5;
    localparam int CNT_W      = 8;
    localparam int LIMIT      = 1000;

    typedef struct {
        logic [2:0] seg0;
        logic [1:0] seg1;
        logic [3:0] rep;
        logic       mod_en;
        int         exp_len;
        int         exp_high;
        int         exp_out_high;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ir_frame_tx_if #(.W0(W0), .W1(W1)) bus ();

    ir_frame_tx #(
        .W0(W0), .W1(W1), .CAR_DIV(CAR_DIV),
        .LEAD_MARK(LEAD_MARK), .LEAD_SPACE(LEAD_SPACE),
        .BIT_MARK(BIT_MARK), .ZERO_SPACE(ZERO_SPACE), .ONE_SPACE(ONE_SPACE),
        .CONN_MARK(CONN_MARK), .CONN_SPACE(CONN_SPACE),
        .FRAME_GAP(FRAME_GAP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference waveform and captured waveform.
    bit exp_env [0:LIMIT-1];
    bit exp_out [0:LIMIT-1];
    int exp_n;
    bit got_env [0:LIMIT-1];
    bit got_out [0:LIMIT-1];
    int got_n;
    int got_done;
    int busy_low;
    int env_high;
    int out_high;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_run(input bit lvl, input int len, input bit mod);
        for (int k = 0; k < len; k++) begin
            exp_env[exp_n] = lvl;
            exp_out[exp_n] = lvl && (!mod || ((k % CAR_DIV) < (CAR_DIV / 2)));
            exp_n++;
        end
    endtask

    task automatic build_model(input logic [2:0] s0, input logic [1:0] s1,
                               input int rep, input bit mod);
        exp_n = 0;
        for (int f = 0; f <= rep; f++) begin
            add_run(1'b1, LEAD_MARK, mod);
            add_run(1'b0, LEAD_SPACE, mod);
            for (int b = W0 - 1; b >= 0; b--) begin
                add_run(1'b1, BIT_MARK, mod);
                add_run(1'b0, s0[b] ? ONE_SPACE : ZERO_SPACE, mod);
            end
            add_run(1'b1, CONN_MARK, mod);
            add_run(1'b0, CONN_SPACE, mod);
            for (int b = W1 - 1; b >= 0; b--) begin
                add_run(1'b1, BIT_MARK, mod);
                add_run(1'b0, s1[b] ? ONE_SPACE : ZERO_SPACE, mod);
            end
            add_run(1'b1, BIT_MARK, mod);
            if (f < rep) add_run(1'b0, FRAME_GAP, mod);
        end
    endtask

    // Waits for tx_ready, presents a request and returns at the negedge of
    // the first cycle after the accept edge.
    task automatic send(input vec_t v, input bit hold);
        int waited = 0;
        while (!bus.tx_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", int'(bus.tx_ready), 1);
        bus.seg0     = v.seg0;
        bus.seg1     = v.seg1;
        bus.rep      = v.rep;
        bus.mod_en   = v.mod_en;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    // Records outputs each cycle until done (bounded). Optionally scrambles
    // the payload inputs every cycle while the frame is in flight.
    task automatic capture(input bit scramble);
        got_n = 0; got_done = 0; busy_low = 0; env_high = 0; out_high = 0;
        for (int c = 0; c < LIMIT; c++) begin
            if (bus.done) begin
                got_done = 1;
                break;
            end
            got_env[got_n] = bus.ir_env;
            got_out[got_n] = bus.ir_out;
            if (!bus.busy)  busy_low++;
            if (bus.ir_env) env_high++;
            if (bus.ir_out) out_high++;
            got_n++;
            if (scramble) begin
                bus.seg0   = 3'($urandom);
                bus.seg1   = 2'($urandom);
                bus.rep    = 4'($urandom);
                bus.mod_en = 1'($urandom);
            end
            @(negedge clk);
        end
    endtask

    // Called at the negedge of the done cycle (or after a timeout); finishes
    // at the negedge of the following IDLE cycle.
    task automatic compare_frame(input string tag, input int exp_len,
                                 input int exp_high, input int exp_out_high);
        int mism = -1;
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_len"}, got_n, exp_len);
        check({tag, "_env_high"}, env_high, exp_high);
        check({tag, "_out_high"}, out_high, exp_out_high);
        check({tag, "_busy_low"}, busy_low, 0);
        for (int i = 0; i < got_n && i < exp_n; i++) begin
            if (mism < 0 && (got_env[i] != exp_env[i] || got_out[i] != exp_out[i]))
                mism = i;
        end
        check({tag, "_wave_first_bad_cycle"}, mism, -1);
        check({tag, "_ready_in_done"}, int'(bus.tx_ready), 0);
        check({tag, "_env_in_done"}, int'(bus.ir_env), 0);
        @(negedge clk);
        check({tag, "_done_width"}, int'(bus.done), 0);
        check({tag, "_ready_after"}, int'(bus.tx_ready), 1);
    endtask

    initial begin
        vec_t v;

        // seg0, seg1, rep, mod_en, length to done, env-high, out-high
        vecs[0] = '{3'b101, 2'b01, 4'd0, 1'b0,  48, 22, 22};
        vecs[1] = '{3'b101, 2'b01, 4'd0, 1'b1,  48, 22, 18};
        vecs[2] = '{3'b000, 2'b00, 4'd0, 1'b0,  42, 22, 22};
        vecs[3] = '{3'b111, 2'b11, 4'd0, 1'b0,  52, 22, 22};
        vecs[4] = '{3'b101, 2'b01, 4'd2, 1'b0, 154, 66, 66};
        vecs[5] = '{3'b010, 2'b10, 4'd1, 1'b1,  97, 44, 36};

        bus.tx_valid = 1'b0;
        bus.seg0     = '0;
        bus.seg1     = '0;
        bus.rep      = '0;
        bus.mod_en   = 1'b0;

        // Reset values, before any request.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ir_out",   int'(bus.ir_out),   0);
        check("rst_ir_env",   int'(bus.ir_env),   0);
        check("rst_done",     int'(bus.done),     0);
        check("rst_busy",     int'(bus.busy),     0);
        check("rst_tx_ready", int'(bus.tx_ready), 1);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            build_model(v.seg0, v.seg1, int'(v.rep), v.mod_en);
            send(v, 1'b0);
            capture(1'b0);
            compare_frame($sformatf("vec%0d", i), v.exp_len, v.exp_high, v.exp_out_high);
        end

        // Mod-enabled lead mark carrier pattern, explicitly.
        v = vecs[1];
        send(v, 1'b0);
        begin
            logic [7:0] lead_pat;
            for (int k = 0; k < 8; k++) begin
                lead_pat[7-k] = bus.ir_out;
                @(negedge clk);
            end
            check("lead_carrier_pattern", int'(lead_pat), 8'b1100_1100);
        end
        capture(1'b0);
        check("lead_carrier_frame_done", got_done, 1);
        @(negedge clk);

        // Held request with scrambled inputs during busy; the second request
        // is taken in the IDLE cycle right after done.
        v = vecs[0];
        build_model(v.seg0, v.seg1, 0, 1'b0);
        send(v, 1'b1);
        capture(1'b1);
        bus.seg0   = 3'b000;
        bus.seg1   = 2'b00;
        bus.rep    = 4'd0;
        bus.mod_en = 1'b0;
        compare_frame("held_first", 48, 22, 22);
        check("held_idle_env", int'(bus.ir_env), 0);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("held_second_start_env", int'(bus.ir_env), 1);
        build_model(3'b000, 2'b00, 0, 1'b0);
        capture(1'b0);
        compare_frame("held_second", 42, 22, 22);

        // Asynchronous reset in the middle of S0_S (cycle 16 of the frame).
        v = vecs[1];
        send(v, 1'b0);
        repeat (15) @(negedge clk);
        check("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_ir_out",   int'(bus.ir_out),   0);
        check("mid_rst_ir_env",   int'(bus.ir_env),   0);
        check("mid_rst_tx_ready", int'(bus.tx_ready), 1);
        check("mid_rst_busy",     int'(bus.busy),     0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        build_model(v.seg0, v.seg1, 0, v.mod_en);
        send(v, 1'b0);
        capture(1'b0);
        compare_frame("post_rst", v.exp_len, v.exp_high, v.exp_out_high);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
